// File: rtl/reg_pkg.sv
// Shared configuration and packed lane types for the register file and its issue/writeback control.
package reg_pkg;

  localparam int unsigned PARALLEL_ORDER = 2;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_DATA_WIDTH = 32;

  localparam int unsigned STALL_CNT_WIDTH = 16;
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = '1;

  typedef logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] lane_addr_t;
  typedef logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] lane_data_t;

endpackage

// File: rtl/reg_write_merge.sv
// Merges writeback lanes onto the register-file write ports; the highest lane wins an address collision.
module reg_write_merge
  import reg_pkg::*;
#(
  parameter int unsigned PARALLEL_ORDER = reg_pkg::PARALLEL_ORDER,
  parameter int unsigned REG_ADDR_WIDTH = reg_pkg::REG_ADDR_WIDTH,
  parameter int unsigned REG_DATA_WIDTH = reg_pkg::REG_DATA_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [PARALLEL_ORDER-1:0]                       wb_valid,
  input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   wb_addr,
  input  logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   wb_data,
  output logic [PARALLEL_ORDER-1:0]                       w_valid,
  output logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   w_addr,
  output logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   w_data
);

  logic [PARALLEL_ORDER-1:0]                     w_valid_d, w_valid_q;
  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] w_addr_q;
  logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] w_data_q;

  always_comb begin
    w_valid_d = wb_valid;
    for (int unsigned i = 0; i < PARALLEL_ORDER; i++) begin
      for (int unsigned k = i + 1; k < PARALLEL_ORDER; k++) begin
        if (wb_valid[k] && (wb_addr[k] == wb_addr[i])) w_valid_d[i] = 1'b0;
      end
    end
  end

  // Address/data load on any valid lane, even a masked loser; they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_q <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      w_valid_q <= w_valid_d;
      for (int unsigned i = 0; i < PARALLEL_ORDER; i++) begin
        if (wb_valid[i]) begin
          w_addr_q[i] <= wb_addr[i];
          w_data_q[i] <= wb_data[i];
        end
      end
    end
  end

  assign w_valid = w_valid_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;

endmodule

// File: rtl/reg_issue_ctrl.sv
// Busy scoreboard, in-order hazard-free issue grant and stall counter in front of the register file.
module reg_issue_ctrl
  import reg_pkg::*;
#(
  parameter int unsigned PARALLEL_ORDER = reg_pkg::PARALLEL_ORDER,
  parameter int unsigned REG_ADDR_WIDTH = reg_pkg::REG_ADDR_WIDTH,
  parameter int unsigned REG_DATA_WIDTH = reg_pkg::REG_DATA_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [PARALLEL_ORDER-1:0]                       iss_valid,
  output logic [PARALLEL_ORDER-1:0]                       iss_ready,
  input  logic [PARALLEL_ORDER-1:0]                       iss_src1_valid,
  input  logic [PARALLEL_ORDER-1:0]                       iss_src2_valid,
  input  logic [PARALLEL_ORDER-1:0]                       iss_dst_valid,
  input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   iss_src1,
  input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   iss_src2,
  input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   iss_dst,
  input  logic [PARALLEL_ORDER-1:0]                       wb_valid,
  input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   wb_addr,
  input  logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   wb_data,
  output logic [PARALLEL_ORDER-1:0]                       w_valid,
  output logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0]   w_addr,
  output logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0]   w_data,
  output logic [(1<<REG_ADDR_WIDTH)-1:0]                  busy,
  output logic [STALL_CNT_WIDTH-1:0]                      stall_cnt
);

  localparam int unsigned NREG = 1 << REG_ADDR_WIDTH;

  logic [NREG-1:0]            busy_d, busy_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
  logic [PARALLEL_ORDER-1:0]  hazard;

  reg_write_merge #(
    .PARALLEL_ORDER(PARALLEL_ORDER),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .REG_DATA_WIDTH(REG_DATA_WIDTH)
  ) u_write_merge (
    .clk     (clk),
    .rst     (rst),
    .wb_valid(wb_valid),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .w_valid (w_valid),
    .w_addr  (w_addr),
    .w_data  (w_data)
  );

  // A lower lane's destination counts as a hazard even if that lane is itself stalled.
  always_comb begin
    logic order_ok;
    order_ok  = 1'b1;
    hazard    = '0;
    iss_ready = '0;
    for (int unsigned i = 0; i < PARALLEL_ORDER; i++) begin
      hazard[i] = (iss_src1_valid[i] && busy_q[iss_src1[i]]) ||
                  (iss_src2_valid[i] && busy_q[iss_src2[i]]) ||
                  (iss_dst_valid[i]  && busy_q[iss_dst[i]]);
      for (int unsigned j = 0; j < i; j++) begin
        if (iss_valid[j] && iss_dst_valid[j] &&
            ((iss_src1_valid[i] && (iss_src1[i] == iss_dst[j])) ||
             (iss_src2_valid[i] && (iss_src2[i] == iss_dst[j])) ||
             (iss_dst_valid[i]  && (iss_dst[i]  == iss_dst[j]))))
          hazard[i] = 1'b1;
      end
      iss_ready[i] = !hazard[i] && order_ok;
      order_ok     = order_ok && (!iss_valid[i] || iss_ready[i]);
    end
  end

  // Clears are applied first so a same-edge issue to the same address keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < PARALLEL_ORDER; i++) begin
      if (w_valid[i]) busy_d[w_addr[i]] = 1'b0;
    end
    for (int unsigned i = 0; i < PARALLEL_ORDER; i++) begin
      if (iss_valid[i] && iss_ready[i] && iss_dst_valid[i]) busy_d[iss_dst[i]] = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(iss_valid & ~iss_ready) && (stall_cnt_q != STALL_CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/reg_issue_ctrl.md
# reg_issue_ctrl

Issue and writeback controller for the parallel `register` file. It owns a per-register busy scoreboard and grants up to `PARALLEL_ORDER` issue requests per cycle, in lane order, when they have no RAW or WAW hazard. It also merges writeback lanes onto the register file write ports, resolving same-address collisions. It sits between the lane issue logic and the `register` block's `w_*` ports.

## Interface
- `PARALLEL_ORDER`, default 2: number of lanes, indexed [P-1:0].
- `REG_ADDR_WIDTH`, default 5: register address width (A). The file holds 2^A registers.
- `REG_DATA_WIDTH`, default 32: register data width (D).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `iss_valid`  in  [P]: issue request per lane.
- `iss_ready`  out  [P]: issue grant per lane (combinational).
- `iss_src1_valid`, `iss_src2_valid`, `iss_dst_valid`  in  [P] each: operand-used flags.
- `iss_src1`, `iss_src2`, `iss_dst`  in  [P][A] each: operand addresses.
- `wb_valid`  in  [P]: writeback request per lane.
- `wb_addr`  in  [P][A]: writeback address.
- `wb_data`  in  [P][D]: writeback data.
- `w_valid`  out  [P]: drives `register.w_valid` (registered).
- `w_addr`  out  [P][A]: drives `register.w_addr` (registered).
- `w_data`  out  [P][D]: drives `register.w_data` (registered).
- `busy`  out  [2^A]: scoreboard state.
- `stall_cnt`  out  16: saturating stall-cycle counter.

## Operation
- **Lane hazard.** Lane i has a hazard if any of these holds:
  - (`src1_valid` & `busy[src1]`), or (`src2_valid` & `busy[src2]`), or (`dst_valid` & `busy[dst]`).
  - Any lane j<i with `iss_valid[j]` & `iss_dst_valid[j]` has `iss_dst[j]` equal to a used src or dst of lane i.
- **Grant rule.** `iss_ready[i]` = !hazard_i & (for every j<i: !`iss_valid[j]` | `iss_ready[j]`).
  - Issue is strictly in order: a stalled lower lane blocks all higher lanes.
  - `iss_ready` does not depend on the lane's own `iss_valid`.
- **Transfer.** A transfer occurs when `iss_valid` & `iss_ready`. If `dst_valid`, it sets `busy[dst]` at the clock edge.
- **Write merge.**
  - `w_valid[i]` <= `wb_valid[i]` & no k>i with `wb_valid[k]` & `wb_addr[k]`==`wb_addr[i]`. The highest lane wins a collision.
  - `w_addr` and `w_data` are loaded from `wb_*` every cycle in which `wb_valid[i]` is set; otherwise they hold.
- **Busy clear.** Busy bits are cleared from the registered `w_valid`/`w_addr`, i.e. on the same edge the register file commits the data.
- **Simultaneous set and clear** on the same address: set wins, and busy stays 1.
- **No bypass.** There is no forwarding from `wb_*` to issue.
- **Stall counter.** `stall_cnt` increments by 1 in each cycle where any lane has `iss_valid` & !`iss_ready`. It saturates at 0xFFFF.
- **Reset values.**
  - `busy`=0, `w_valid`=0, `w_addr`=0, `w_data`=0, `stall_cnt`=0.
  - Reset during operation drops all pending ownership, so everything is issuable the cycle after reset deasserts.

## Timing
- `iss_ready` is valid in the same cycle as the requests. Its combinational path depends only on the `iss_*` inputs and the registered `busy`.
- Issue at cycle t → `busy[dst]`=1 from t+1.
- Writeback at cycle t → `w_*` driven at t+1 → busy cleared and data in the register file from t+2 → a dependent issue is grantable at t+2.
- No outputs other than `iss_ready` are combinational from inputs.

## Structure
- **Shared package `reg_pkg`:** holds `PARALLEL_ORDER`, `REG_ADDR_WIDTH` and `REG_DATA_WIDTH`, replacing the global macros. It also holds the packed lane types `lane_addr_t` ([P][A]) and `lane_data_t` ([P][D]). `register` and this block share the package.
- **Sub-module `reg_write_merge`:** contains the collision masking plus the `w_*` output registers. It outputs `w_valid`/`w_addr`, which the scoreboard reuses for clearing.
- **Scoreboard, grant logic and counter** stay in the top module.

## Test plan
- **Write collision.** Lanes 0 and 1 both write back addr 1, data 4 and 5 → next cycle `w_valid`=2'b10, `w_data[1]`=5; a subsequent `register` read of addr 1 returns 5.
- **RAW.**
  - Lane 0 issues dst=3 → `busy[3]`=1.
  - Next cycle lane 0 has src1=3 → `iss_ready`=0 and `stall_cnt` increments.
  - Writeback of addr 3 at cycle t → `iss_ready[0]`=1 at t+2, not at t+1.
- **Intra-group hazard.** Same cycle: lane 0 dst=7, lane 1 src2=7 → `iss_ready`=2'b01. Next cycle lane 1 is still stalled because `busy[7]`=1.
- **In-order.** Lane 0 stalled on `busy[2]`, lane 1 independent → `iss_ready`=2'b00.
- **Set/clear collision.** Issue dst=5 on the same edge that `w_valid` clears addr 5 → `busy[5]` stays 1.
- **Reset mid-operation.**
  - Assert `rst` with `busy`≠0 and `w_valid`≠0 → all outputs 0 immediately, without waiting for a clock edge.
  - After deassert, any request is granted.
  - `stall_cnt` saturation: hold a stall for 70000 cycles → `stall_cnt`=0xFFFF.
